md_sched: RTL

Multi-cycle multiply/divide scheduler for the five-stage MIPS pipeline. It accepts HI/LO-class operations issued from the E stage, holds the shared HI/LO result pair busy for a fixed latency, and commits the result at the end. It also drives the D-stage stall request whenever a multiply/divide-class instruction in D would collide with an in-flight or just-issued operation. It sits beside the E-stage ALU, and its `stall` output is ORed into the existing hazard stall.

---
 rtl/md_sched.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/md_sched.sv
// md_sched: multi-cycle multiply/divide scheduler for the 5-stage MIPS pipeline.
//
// Accepts HI/LO-class ops from E. A mult or div keeps the unit busy for a fixed
// number of cycles. Its result is held in a pending pair (phi/plo) and is
// committed to HI/LO at the end of that period. mthi/mtlo write HI/LO directly
// at the issue edge. The unit also raises the D-stage stall request.
//
// Ports:
//   clk      - clock, rising edge
//   reset    - asynchronous active-low reset
//   start    - E-stage instruction is an md op this cycle
//   op[2:0]  - 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 no-op
//   a, b     - forwarded rs / rt operands
//   d_is_md  - D-stage instruction is an md-class instruction
//   busy     - a mult/div is in flight (registered-state decode)
//   hi, lo   - committed HI/LO registers
//   done     - one-cycle pulse when new mult/div results first appear on hi/lo
//   stall    - freeze PC/D and bubble E (combinational)
module md_sched #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        d_is_md,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        done,
    output logic        stall
);

    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     phi_q, phi_d, plo_q, plo_d;
    logic [31:0]     hi_q, hi_d, lo_q, lo_d;
    logic            done_q, done_d;

    // ---------------- product ----------------
    logic [63:0] ext_a, ext_b, prod;
    assign ext_a = (op == 3'd0) ? {{32{a[31]}}, a} : {32'b0, a};
    assign ext_b = (op == 3'd0) ? {{32{b[31]}}, b} : {32'b0, b};
    // The low 64 bits of the product of the sign-extended operands are the
    // exact signed product, so one multiplier serves mult and multu.
    assign prod  = ext_a * ext_b;

    // ---------------- quotient / remainder ----------------
    // Signed division is done on magnitudes, then the signs are fixed up.
    // That gives truncation toward zero and a remainder carrying the dividend
    // sign. It also handles 0x80000000 / -1 with no overflow case: the
    // magnitudes are 0x80000000 / 1, and both operands are negative.
    logic        neg_a, neg_b;
    logic [31:0] mag_a, mag_b, div_b, q_mag, r_mag, quot, rem;
    assign neg_a = (op == 3'd2) & a[31];
    assign neg_b = (op == 3'd2) & b[31];
    assign mag_a = neg_a ? (~a + 32'd1) : a;
    assign mag_b = neg_b ? (~b + 32'd1) : b;
    // Never divide by zero in hardware. The b==0 result is replaced below.
    assign div_b = (b == 32'd0) ? 32'd1 : mag_b;
    assign q_mag = mag_a / div_b;
    assign r_mag = mag_a % div_b;
    assign quot  = (neg_a ^ neg_b) ? (~q_mag + 32'd1) : q_mag;
    assign rem   = neg_a ? (~r_mag + 32'd1) : r_mag;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            phi_q   <= '0;
            plo_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phi_d   = phi_q;
        plo_d   = plo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    case (op)
                        3'd0, 3'd1: begin
                            {phi_d, plo_d} = prod;
                            cnt_d          = CW'(MUL_CYCLES);
                            state_d        = MUL;
                        end
                        3'd2, 3'd3: begin
                            // A divide by zero re-commits the current HI/LO.
                            if (b == 32'd0) begin
                                phi_d = hi_q;
                                plo_d = lo_q;
                            end else begin
                                phi_d = rem;
                                plo_d = quot;
                            end
                            cnt_d   = CW'(DIV_CYCLES);
                            state_d = DIV;
                        end
                        3'd4:    hi_d = a;
                        3'd5:    lo_d = a;
                        default: ;
                    endcase
                end
            end
            MUL, DIV: begin
                // A start while busy is ignored here.
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    hi_d    = phi_q;
                    lo_d    = plo_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy  = (state_q != IDLE);
    assign hi    = hi_q;
    assign lo    = lo_q;
    assign done  = done_q;
    // op <= 3 means the op is a mult or div issuing from E.
    assign stall = d_is_md & (busy | (start & ~op[2]));

endmodule
